// File: rtl/disp_32x4.sv
// disp_32x4: one-to-four dispatcher with a one-entry slot per output lane.
// A beat is steered to the lane named by a one-hot select. A beat whose
// select is not one-hot is consumed and dropped; drops are counted in a
// saturating counter and flagged by a sticky error bit.
module disp_32x4 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [3:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic             err,
  input  logic             err_clr,
  output logic [7:0]       drop_cnt,
  output logic             busy
);

  localparam int unsigned SEL_W = 4;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SEL_W-1:0] valid_q;
  logic [SEL_W-1:0] valid_d;
  logic [WIDTH-1:0] data_q [LANES];
  logic [SEL_W-1:0] load;
  logic             sel_onehot;
  logic             drop;
  logic             err_d;
  logic [CNT_W-1:0] cnt_d;

  // Select decode, acceptance and per-lane load strobes.
  always_comb begin
    in_ready   = 1'b1;
    load       = '0;
    sel_onehot = (in_sel != '0) && ((in_sel & (in_sel - SEL_W'(1))) == '0);
    // Only the addressed lane gates readiness; a full lane frees up when it drains this cycle.
    if (sel_onehot) begin
      in_ready = |(in_sel & (~valid_q | out_ready));
    end
    drop = in_valid && !sel_onehot;
    if (in_valid && sel_onehot && in_ready) begin
      load = in_sel;
    end
  end

  // Next slot occupancy: a load wins over a same-cycle dequeue (no bubble).
  always_comb begin
    valid_d = load | (valid_q & ~out_ready);
  end

  // Next error state: a drop wins over a same-cycle clear.
  always_comb begin
    err_d = err;
    cnt_d = drop_cnt;
    if (drop) begin
      err_d = 1'b1;
      if (err_clr) begin
        cnt_d = CNT_W'(1);
      end else if (drop_cnt != CNT_MAX) begin
        cnt_d = drop_cnt + CNT_W'(1);
      end
    end else if (err_clr) begin
      err_d = 1'b0;
      cnt_d = '0;
    end
  end

  // Slot valid bits and the registered busy summary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      busy    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      busy    <= |valid_d;
    end
  end

  // Slot data registers; data is held after a dequeue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (load[i]) begin
          data_q[i] <= in_data;
        end
      end
    end
  end

  // Sticky error flag and saturating drop counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      err      <= err_d;
      drop_cnt <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];

endmodule

// File: tb/tb_disp_32x4.sv
// Bench for disp_32x4: behavioural lane/drop model plus directed and random beats.
module tb_disp_32x4;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data0, out_data1, out_data2, out_data3;
  logic        err;
  logic        err_clr;
  logic [7:0]  drop_cnt;
  logic        busy;

  disp_32x4 #(.WIDTH(32), .LANES(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
    .err(err), .err_clr(err_clr), .drop_cnt(drop_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: which lanes hold a beat, the data each holds, error flag and drop count.
  bit          mv [4];
  logic [31:0] md [4];
  bit          merr;
  int          mcnt;

  int   total = 0;
  int   bad   = 0;
  logic rdy_seen;

  logic [31:0] od [4];
  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mv[i] = 0;
      md[i] = '0;
    end
    merr = 0;
    mcnt = 0;
  endtask

  // Compare every registered output against the model.
  task automatic compare_outputs();
    bit any;
    any = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("out_valid[%0d]", i), 64'(out_valid[i]), 64'(mv[i]));
      chk($sformatf("out_data%0d", i), 64'(od[i]), 64'(md[i]));
      any = any | mv[i];
    end
    chk("err", 64'(err), 64'(merr));
    chk("drop_cnt", 64'(drop_cnt), 64'(mcnt));
    chk("busy", 64'(busy), 64'(any));
  endtask

  // One clock of stimulus: drive after the falling edge, check, then advance the model at the rising edge.
  task automatic cycle(input logic iv, input logic [3:0] sel, input logic [31:0] d,
                       input logic [3:0] ordy, input logic clr);
    bit onehot;
    int lane;
    bit exp_rdy;
    in_valid  = iv;
    in_sel    = sel;
    in_data   = d;
    out_ready = ordy;
    err_clr   = clr;
    #1;
    compare_outputs();
    onehot = ($countones(sel) == 1);
    lane = 0;
    for (int i = 0; i < 4; i++) if (sel[i]) lane = i;
    exp_rdy = onehot ? (!mv[lane] || ordy[lane]) : 1'b1;
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    rdy_seen = in_ready;
    @(posedge clk);
    for (int i = 0; i < 4; i++) if (mv[i] && ordy[i]) mv[i] = 0;
    if (iv && onehot && exp_rdy) begin
      mv[lane] = 1;
      md[lane] = d;
    end
    if (iv && !onehot) begin
      merr = 1;
      mcnt = clr ? 1 : ((mcnt < 255) ? mcnt + 1 : 255);
    end else if (clr) begin
      merr = 0;
      mcnt = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_sel = 4'b0000; in_data = '0;
    out_ready = 4'b0000; err_clr = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    // Reset state and combinational in_ready during reset.
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_data0", 64'(out_data0), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    in_sel = 4'b0001; in_valid = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    @(negedge clk);
    chk("rst_no_accept", 64'(out_valid), 64'h0);
    in_valid = 1'b0;
    reset = 1'b0;

    // Single beat held on a stalled lane 2.
    cycle(1'b1, 4'b0100, 32'hDEADBEEF, 4'b0000, 1'b0);
    chk("single_valid", 64'(out_valid), 64'h4);
    chk("single_data2", 64'(out_data2), 64'hDEADBEEF);
    chk("single_busy", 64'(busy), 64'h1);
    cycle(1'b1, 4'b0100, 32'h0BADF00D, 4'b0000, 1'b0);
    chk("single_second_rdy", 64'(rdy_seen), 64'h0);
    chk("single_data2_kept", 64'(out_data2), 64'hDEADBEEF);

    // Pass-through on a full lane 1 that drains in the same cycle.
    cycle(1'b1, 4'b0010, 32'hAAAA5555, 4'b0000, 1'b0);
    cycle(1'b1, 4'b0010, 32'h12345678, 4'b0010, 1'b0);
    chk("pass_rdy", 64'(rdy_seen), 64'h1);
    chk("pass_valid1", 64'(out_valid[1]), 64'h1);
    chk("pass_data1", 64'(out_data1), 64'h12345678);

    // Independence: lane 0 stalled, lanes 3 and 1 still accept back-to-back.
    cycle(1'b0, 4'b0000, 32'h0, 4'b1111, 1'b0);
    chk("drained", 64'(out_valid), 64'h0);
    cycle(1'b1, 4'b0001, 32'h00000A00, 4'b0000, 1'b0);
    cycle(1'b1, 4'b1000, 32'h00000B03, 4'b0000, 1'b0);
    chk("indep_rdy3", 64'(rdy_seen), 64'h1);
    cycle(1'b1, 4'b0010, 32'h00000C01, 4'b0000, 1'b0);
    chk("indep_rdy1", 64'(rdy_seen), 64'h1);
    chk("indep_valid", 64'(out_valid), 64'hB);
    chk("indep_data3", 64'(out_data3), 64'h00000B03);

    // Bad selects are dropped and counted; clear, then clear racing a drop.
    cycle(1'b1, 4'b0000, 32'h1, 4'b0000, 1'b0);
    chk("bad0_rdy", 64'(rdy_seen), 64'h1);
    cycle(1'b1, 4'b0011, 32'h2, 4'b0000, 1'b0);
    chk("bad3_rdy", 64'(rdy_seen), 64'h1);
    cycle(1'b1, 4'b1111, 32'h3, 4'b0000, 1'b0);
    chk("badF_rdy", 64'(rdy_seen), 64'h1);
    chk("bad_valid_same", 64'(out_valid), 64'hB);
    chk("bad_err", 64'(err), 64'h1);
    chk("bad_cnt", 64'(drop_cnt), 64'h3);
    cycle(1'b0, 4'b0000, 32'h0, 4'b0000, 1'b1);
    chk("clr_err", 64'(err), 64'h0);
    chk("clr_cnt", 64'(drop_cnt), 64'h0);
    cycle(1'b1, 4'b0110, 32'h4, 4'b0000, 1'b1);
    chk("clr_drop_err", 64'(err), 64'h1);
    chk("clr_drop_cnt", 64'(drop_cnt), 64'h1);

    // Saturation of the drop counter.
    for (int i = 0; i < 300; i++) cycle(1'b1, 4'b0000, 32'($urandom), 4'b0000, 1'b0);
    chk("sat_cnt", 64'(drop_cnt), 64'hFF);
    chk("sat_err", 64'(err), 64'h1);

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      logic [3:0] sel;
      if ($urandom_range(0, 3) != 0) sel = 4'(1 << $urandom_range(0, 3));
      else sel = 4'($urandom_range(0, 15));
      cycle(1'b1 & ($urandom_range(0, 3) != 0), sel, 32'($urandom),
            4'($urandom_range(0, 15)), ($urandom_range(0, 19) == 0));
    end

    // Reset with all lanes full discards everything at once.
    cycle(1'b0, 4'b0000, 32'h0, 4'b1111, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'(1 << i), 32'hF0 + 32'(i), 4'b0000, 1'b0);
    chk("full_valid", 64'(out_valid), 64'hF);
    in_valid = 1'b0; out_ready = 4'b0000; err_clr = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'h0);
    chk("midrst_busy", 64'(busy), 64'h0);
    chk("midrst_data3", 64'(out_data3), 64'h0);
    chk("midrst_cnt", 64'(drop_cnt), 64'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b0, 4'b0000, 32'h0, 4'b0000, 1'b0);
    cycle(1'b1, 4'b0001, 32'h00C0FFEE, 4'b0000, 1'b0);
    chk("postrst_valid", 64'(out_valid), 64'h1);
    chk("postrst_data0", 64'(out_data0), 64'h00C0FFEE);
    cycle(1'b0, 4'b0000, 32'h0, 4'b0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/disp_32x4.md
DISP_32X4 -- requirements
Module: disp_32x4

Interface
REQ-001 SHALL have parameter: WIDTH, 32, data width of the input and every output lane.
REQ-002 SHALL have parameter: LANES, 4, number of output lanes; the one-hot select width is fixed at 4.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: in_valid  input  1  input beat present.
REQ-006 SHALL have port: in_ready  output  1  input beat accepted this cycle when high with in_valid.
REQ-007 SHALL have port: in_data  input  WIDTH  payload.
REQ-008 SHALL have port: in_sel  input  4  one-hot destination lane.
REQ-009 SHALL have port: out_valid  output  4  per-lane slot holds a beat.
REQ-010 SHALL have port: out_ready  input  4  per-lane consumer ready.
REQ-011 SHALL have ports: out_data0..out_data3  output  WIDTH each  per-lane slot data.
REQ-012 SHALL have port: err  output  1  sticky flag for a dropped beat with a non-one-hot select.
REQ-013 SHALL have port: err_clr  input  1  synchronous clear of err and drop_cnt.
REQ-014 SHALL have port: drop_cnt  output  8  saturating count of dropped beats.
REQ-015 SHALL have port: busy  output  1  OR of out_valid.

Function
REQ-016 Each lane i SHALL hold a one-entry slot: a valid bit (drives out_valid[i]) and a WIDTH-bit data register (drives out_data<i>).
REQ-017 A beat SHALL be accepted on a cycle when in_valid and in_ready are both high.
REQ-018 When in_sel is one-hot with bit i set, in_ready SHALL equal (NOT out_valid[i]) OR out_ready[i]; this is a combinational path from out_ready.
REQ-019 When in_sel is not one-hot (0000 or more than one bit set), in_ready SHALL be 1; the beat is consumed and dropped, with no broadcast to any lane.
REQ-020 Accepting a one-hot beat for lane i SHALL set slot i valid and load in_data at the next edge, giving 1-cycle latency from acceptance to out_valid[i].
REQ-021 Slot i SHALL clear when out_valid[i] and out_ready[i] are high and no load to lane i occurs in the same cycle.
REQ-022 A dequeue and a load on the same lane in the same cycle SHALL leave valid high and update the data with the new beat, with no bubble.
REQ-023 Lanes SHALL be independent: a stall on one lane SHALL NOT block beats destined for other lanes.
REQ-024 Per-lane order SHALL be preserved.
REQ-025 out_data<i> SHALL retain its last value after a dequeue; it is don't-care while out_valid[i] is 0.
REQ-026 A dropped beat SHALL set err at the next edge and increment drop_cnt, saturating at 255.
REQ-027 err_clr SHALL zero err and drop_cnt at the next edge; if a drop occurs in the same cycle, the drop wins (err=1, drop_cnt=1).
REQ-028 When in_valid is low, no state SHALL change except dequeues.
REQ-029 The in_sel/in_data inputs SHALL only be sampled when in_valid is high.

Reset
REQ-030 While reset is high, out_valid=0000, out_data0..3=0, err=0, drop_cnt=0, and busy=0, applied asynchronously.
REQ-031 in_ready SHALL remain combinationally defined during reset; no acceptance SHALL take effect until the first edge after reset deasserts.
REQ-032 Asserting reset mid-operation SHALL discard all held beats without any out_valid glitch after release.

Verification
REQ-033 Single beat: in_sel=0100, in_data=0xDEADBEEF, out_ready=0000 -> next cycle out_valid=0100, out_data2=0xDEADBEEF, busy=1; a second beat to lane 2 sees in_ready=0.
REQ-034 Pass-through: lane 1 full, out_ready[1]=1, new beat 0x12345678 to 0010 -> in_ready=1; next cycle out_valid[1]=1, out_data1=0x12345678.
REQ-035 Independence: lane 0 stalled with a full slot; beats to 1000 and 0010 are accepted back-to-back, and lanes 3 and 1 become valid.
REQ-036 Bad select: beats with in_sel=0000, 0011, then 1111 -> in_ready=1 each, out_valid unchanged, err=1, drop_cnt=3; err_clr -> 0/0; err_clr together with a drop -> err=1, drop_cnt=1.
REQ-037 Saturation: 300 dropped beats -> drop_cnt=255.
REQ-038 Reset: reset asserted with all four lanes full -> out_valid=0000 immediately; after release, a beat to 0001 gives out_valid=0001 one cycle later.
